// File: rtl/gpio_arb_pkg.sv
// Shared types and helpers for the gpio0 pad-bank arbiter.
// Latency: none, because this file holds only types and pure functions.
// Backpressure: none.
package gpio_arb_pkg;

   // rr_pick handles up to this many requesters. The index field is sized to match.
   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // Counter or index width for a range of v values. The result is never below 1 bit.
   function automatic int width_of(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   // Round-robin pick: the first set request strictly after 'last', scanning upward with wrap.
   // The scan ends on 'last' itself, so a lone requester can win again.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int n, input int last);
      pick_t            p;
      int               idx;
      logic [IDX_W-1:0] sel;
      p = '0;
      for (int i = 1; i <= MAX_REQ; i++) begin
         if (i <= n && !p.vld) begin
            idx = last + i;
            if (idx >= n) idx = idx - n;
            sel = IDX_W'(idx);
            if (req[sel]) begin
               p.vld = 1'b1;
               p.idx = sel;
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser that brings the raw asynchronous pad inputs into the clock domain.
// Latency: 2 clock cycles from pins to synced.
// Backpressure: none. It samples every cycle.
module gpio_in_sync #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins,
   output logic [WIDTH-1:0] synced
);

   logic [WIDTH-1:0] meta;

   // The first stage may go metastable. The second stage gives it a full cycle to resolve.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= '0;
         synced <= '0;
      end else begin
         meta   <= pins;
         synced <= meta;
      end
   end

endmodule

// File: rtl/gpio_port_arbiter.sv
// Grants round-robin, exclusive ownership of the gpio0 pad bank, with a tri-state turnaround between owners and preemption when an owner holds the bank too long.
// Latency: gnt_o 1 cycle after req_i. The pads follow the owner 1 cycle after gnt_o. in_o is 2 cycles after pin_in_i.
// Backpressure: level req_i/gnt_o handshake. A requester waits, holding req_i high, until it is granted.
module gpio_port_arbiter
   import gpio_arb_pkg::*;
#(
   parameter  int N_REQ    = 4,
   parameter  int WIDTH    = 32,
   parameter  int HOLD_MAX = 1024,
   parameter  int TURN_CYC = 1,
   localparam int OW       = width_of(N_REQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       req_i,
   output logic [N_REQ-1:0]       gnt_o,
   input  logic [N_REQ*WIDTH-1:0] out_i,
   input  logic [N_REQ*WIDTH-1:0] oe_i,
   output logic [WIDTH-1:0]       pin_out_o,
   output logic [WIDTH-1:0]       pin_oe_o,
   input  logic [WIDTH-1:0]       pin_in_i,
   output logic [WIDTH-1:0]       in_o,
   output logic                   busy_o,
   output logic [OW-1:0]          owner_o,
   output logic                   timeout_o
);

   localparam int HW = width_of(HOLD_MAX);
   localparam int TW = width_of(TURN_CYC);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

   arb_state_t       state;
   logic [OW-1:0]    last_q;     // RR pointer. Its reset value differs from owner_o so that slot 0 wins first.
   logic [HW-1:0]    hold_q;
   logic [TW-1:0]    turn_q;

   pick_t            pick;
   logic [OW-1:0]    pick_idx;
   logic             owner_req;
   logic             others_pend;
   logic [WIDTH-1:0] own_out;
   logic [WIDTH-1:0] own_oe;

   // Pick the next owner, and select the current owner's pad drive from the packed buses.
   always_comb begin
      pick        = rr_pick(MAX_REQ'(req_i), N_REQ, int'(last_q));
      pick_idx    = OW'(pick.idx);
      owner_req   = |(req_i & gnt_o);
      others_pend = |(req_i & ~gnt_o);
      own_out     = out_i[int'(owner_o)*WIDTH +: WIDTH];
      own_oe      = oe_i[int'(owner_o)*WIDTH +: WIDTH];
   end

   // Arbiter FSM. Grant, pad, status and timeout outputs are all registered here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         last_q    <= OW'(N_REQ - 1);
         hold_q    <= '0;
         turn_q    <= '0;
         gnt_o     <= '0;
         owner_o   <= '0;
         busy_o    <= 1'b0;
         timeout_o <= 1'b0;
         pin_out_o <= '0;
         pin_oe_o  <= '0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               pin_oe_o <= '0;
               if (pick.vld) begin
                  state   <= GRANT;
                  gnt_o   <= N_REQ'(1) << pick_idx;
                  owner_o <= pick_idx;
                  last_q  <= pick_idx;
                  hold_q  <= '0;
                  busy_o  <= 1'b1;
               end
            end
            GRANT: begin
               if (!owner_req) begin
                  // A normal release takes priority over a timeout in the same cycle.
                  state    <= TURN;
                  gnt_o    <= '0;
                  pin_oe_o <= '0;
                  turn_q   <= '0;
               end else if (hold_q == HOLD_LAST && others_pend) begin
                  state     <= TURN;
                  gnt_o     <= '0;
                  pin_oe_o  <= '0;
                  turn_q    <= '0;
                  timeout_o <= 1'b1;
               end else begin
                  pin_out_o <= own_out;
                  pin_oe_o  <= own_oe;
                  if (hold_q != HOLD_LAST) hold_q <= hold_q + 1'b1;
               end
            end
            TURN: begin
               // The pads stay tri-stated and pin_out_o keeps its last value. Arbitration resumes from IDLE.
               pin_oe_o <= '0;
               if (turn_q == TURN_LAST) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  turn_q <= turn_q + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               gnt_o    <= '0;
               pin_oe_o <= '0;
               busy_o   <= 1'b0;
            end
         endcase
      end
   end

   gpio_in_sync #(
      .WIDTH(WIDTH)
   ) u_in_sync (
      .clk   (clk_i),
      .rst   (rst_i),
      .pins  (pin_in_i),
      .synced(in_o)
   );

endmodule
